// File: rtl/icache_data_ctrl.sv
// Sequencer between I-cache fetch/refill logic and the line-wide data SRAM macro.
// Assembles refill beats into one full-line write and returns single fetch words.
module icache_data_ctrl #(
   parameter int INDEX_WIDTH = 4,
   parameter int LINE_WIDTH  = 256,
   parameter int FILL_WIDTH  = 64,
   parameter int WORD_WIDTH  = 32
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      req_valid,
   output logic                      req_ready,
   input  logic [INDEX_WIDTH-1:0]    req_index,
   input  logic [2:0]                req_offset,
   output logic                      resp_valid,
   input  logic                      resp_ready,
   output logic [WORD_WIDTH-1:0]     resp_rdata,
   input  logic                      fill_valid,
   output logic                      fill_ready,
   input  logic [INDEX_WIDTH-1:0]    fill_index,
   input  logic [FILL_WIDTH-1:0]     fill_data,
   output logic                      fill_done,
   output logic                      sram_csb0,
   output logic                      sram_web0,
   output logic [LINE_WIDTH/8-1:0]   sram_wmask0,
   output logic [INDEX_WIDTH-1:0]    sram_addr0,
   output logic [LINE_WIDTH-1:0]     sram_din0,
   input  logic [LINE_WIDTH-1:0]     sram_dout0
);

   localparam int BEATS = LINE_WIDTH / FILL_WIDTH;
   localparam int BCW   = $clog2(BEATS);
   localparam logic [BCW-1:0] LAST_BEAT = BCW'(BEATS - 1);

   typedef enum logic [1:0] {S_IDLE, S_RD, S_FILL, S_WR} state_e;

   state_e                  state_q, state_d;
   logic [BCW-1:0]          beat_cnt_q, beat_cnt_d;
   logic [LINE_WIDTH-1:0]   line_q, line_d;
   logic [INDEX_WIDTH-1:0]  fill_index_q, fill_index_d;
   logic [2:0]              offset_q, offset_d;
   logic                    resp_valid_q, resp_valid_d;
   logic [WORD_WIDTH-1:0]   resp_rdata_q, resp_rdata_d;
   logic                    fill_done_q, fill_done_d;

   logic                    rd_fire;
   logic                    fill_fire;
   logic [BCW-1:0]          beat_slot;

   // Handshakes: a transfer happens on a rising clk edge where valid && ready are both high.
   assign req_ready  = (state_q == S_IDLE) && !fill_valid && (!resp_valid_q || resp_ready);
   assign fill_ready = (state_q == S_IDLE) || (state_q == S_FILL);
   assign rd_fire    = req_valid && req_ready;
   assign fill_fire  = fill_valid && fill_ready;
   assign beat_slot  = (state_q == S_IDLE) ? '0 : beat_cnt_q;

   assign resp_valid = resp_valid_q;
   assign resp_rdata = resp_rdata_q;
   assign fill_done  = fill_done_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= S_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE: begin
            if (fill_fire) begin
               state_d = S_FILL;
            end else if (rd_fire) begin
               state_d = S_RD;
            end
         end
         S_RD:   state_d = S_IDLE;
         S_FILL: begin
            if (fill_fire && (beat_cnt_q == LAST_BEAT)) begin
               state_d = S_WR;
            end
         end
         S_WR:   state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // SRAM controls are combinational; the macro samples them at the edge closing the cycle.
   always_comb begin
      sram_csb0   = 1'b1;
      sram_web0   = 1'b1;
      sram_wmask0 = '0;
      sram_addr0  = '0;
      sram_din0   = '0;
      case (state_q)
         S_IDLE: begin
            if (rd_fire) begin
               sram_csb0  = 1'b0;
               sram_addr0 = req_index;
            end
         end
         S_WR: begin
            sram_csb0   = 1'b0;
            sram_web0   = 1'b0;
            sram_wmask0 = '1;
            sram_addr0  = fill_index_q;
            sram_din0   = line_q;
         end
         default: ;
      endcase
      if (rst) begin
         sram_csb0 = 1'b1;
      end
   end

   always_comb begin
      beat_cnt_d   = beat_cnt_q;
      line_d       = line_q;
      fill_index_d = fill_index_q;
      offset_d     = offset_q;
      resp_valid_d = resp_valid_q;
      resp_rdata_d = resp_rdata_q;
      fill_done_d  = (state_q == S_WR);

      if (fill_fire) begin
         line_d[int'(beat_slot) * FILL_WIDTH +: FILL_WIDTH] = fill_data;
         beat_cnt_d = beat_slot + BCW'(1);
         if (state_q == S_IDLE) begin
            fill_index_d = fill_index;
         end
      end

      if (rd_fire) begin
         offset_d = req_offset;
      end

      // SRAM dout is only valid around the edge that closes RD, so capture it exactly there.
      if (state_q == S_RD) begin
         resp_valid_d = 1'b1;
         resp_rdata_d = sram_dout0[int'(offset_q) * WORD_WIDTH +: WORD_WIDTH];
      end else if (resp_valid_q && resp_ready) begin
         resp_valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         beat_cnt_q   <= '0;
         line_q       <= '0;
         fill_index_q <= '0;
         offset_q     <= '0;
         resp_valid_q <= 1'b0;
         resp_rdata_q <= '0;
         fill_done_q  <= 1'b0;
      end else begin
         beat_cnt_q   <= beat_cnt_d;
         line_q       <= line_d;
         fill_index_q <= fill_index_d;
         offset_q     <= offset_d;
         resp_valid_q <= resp_valid_d;
         resp_rdata_q <= resp_rdata_d;
         fill_done_q  <= fill_done_d;
      end
   end

endmodule

// File: tb/tb_icache_data_ctrl.sv
// Bench for icache_data_ctrl: behavioural SRAM macro, line-level reference memory,
// response/write scoreboards and randomized fill/read traffic.
module tb_icache_data_ctrl;

   localparam int IW = 4;
   localparam int LW = 256;
   localparam int FW = 64;
   localparam int WW = 32;

   logic            clk = 1'b0;
   logic            rst;
   logic            req_valid, req_ready;
   logic [IW-1:0]   req_index;
   logic [2:0]      req_offset;
   logic            resp_valid, resp_ready;
   logic [WW-1:0]   resp_rdata;
   logic            fill_valid, fill_ready;
   logic [IW-1:0]   fill_index;
   logic [FW-1:0]   fill_data;
   logic            fill_done;
   logic            sram_csb0, sram_web0;
   logic [LW/8-1:0] sram_wmask0;
   logic [IW-1:0]   sram_addr0;
   logic [LW-1:0]   sram_din0;
   logic [LW-1:0]   sram_dout0 = '0;

   always #5 clk = ~clk;

   icache_data_ctrl #(.INDEX_WIDTH(IW), .LINE_WIDTH(LW), .FILL_WIDTH(FW), .WORD_WIDTH(WW)) dut (
      .clk(clk), .rst(rst),
      .req_valid(req_valid), .req_ready(req_ready), .req_index(req_index), .req_offset(req_offset),
      .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_rdata(resp_rdata),
      .fill_valid(fill_valid), .fill_ready(fill_ready), .fill_index(fill_index),
      .fill_data(fill_data), .fill_done(fill_done),
      .sram_csb0(sram_csb0), .sram_web0(sram_web0), .sram_wmask0(sram_wmask0),
      .sram_addr0(sram_addr0), .sram_din0(sram_din0), .sram_dout0(sram_dout0)
   );

   int n_vec = 0;
   int n_err = 0;
   logic [WW-1:0] exp_q[$];
   logic [IW-1:0] wr_idx_q[$];
   logic [LW-1:0] wr_line_q[$];
   logic [LW-1:0] ref_mem [16];
   logic [LW-1:0] sram_mem [16];
   int rr_mode = 0;

   task automatic chk(input string name, input logic [LW-1:0] act, input logic [LW-1:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   function automatic logic [LW-1:0] rand_line();
      logic [LW-1:0] r;
      for (int k = 0; k < LW / 32; k++) r[k*32 +: 32] = $urandom;
      return r;
   endfunction

   // SRAM macro model: command sampled at the closing posedge, array updated / dout
   // driven at the following negedge, dout garbage again shortly after the next posedge.
   logic            pend_rd = 1'b0, pend_wr = 1'b0;
   logic [IW-1:0]   pend_a;
   logic [LW-1:0]   pend_d;
   logic [LW/8-1:0] pend_m;

   always @(negedge clk) begin
      if (pend_wr) begin
         for (int b = 0; b < LW / 8; b++)
            if (pend_m[b]) sram_mem[pend_a][b*8 +: 8] = pend_d[b*8 +: 8];
      end
      if (pend_rd) sram_dout0 = sram_mem[pend_a];
      pend_wr = !rst && !sram_csb0 && !sram_web0;
      pend_rd = !rst && !sram_csb0 && sram_web0;
      pend_a  = sram_addr0;
      pend_d  = sram_din0;
      pend_m  = sram_wmask0;
   end

   always @(posedge clk) begin
      #1;
      for (int k = 0; k < LW / 32; k++) sram_dout0[k*32 +: 32] = $urandom;
   end

   always @(posedge clk) begin
      #1;
      case (rr_mode)
         0:       resp_ready = ($urandom_range(0, 3) != 0);
         1:       resp_ready = 1'b0;
         default: resp_ready = 1'b1;
      endcase
   end

   // Monitor: SRAM write scoreboard, fill_done pulse, response scoreboard and hold checks.
   logic          wrote_prev = 1'b0;
   logic          fill_busy = 1'b0;
   logic          prev_hold = 1'b0;
   logic [WW-1:0] prev_data = '0;
   logic          wr_now;

   always @(negedge clk) begin
      if (rst) begin
         chk("csb_in_reset", sram_csb0, 1);
         wrote_prev = 1'b0;
         fill_busy  = 1'b0;
         prev_hold  = 1'b0;
      end else begin
         chk("fill_done", fill_done, wrote_prev);
         wr_now = !sram_csb0 && !sram_web0;
         if (wr_now) begin
            chk("write_expected", wr_idx_q.size() > 0, 1);
            if (wr_idx_q.size() > 0) begin
               chk("wr_addr", sram_addr0, wr_idx_q.pop_front());
               chk("wr_din", sram_din0, wr_line_q.pop_front());
               chk("wr_mask", sram_wmask0, {(LW/8){1'b1}});
            end
            fill_busy = 1'b0;
         end else begin
            chk("idle_din_zero", sram_din0, 0);
            chk("idle_mask_zero", sram_wmask0, 0);
         end
         chk("no_read_during_fill", fill_busy && !sram_csb0 && sram_web0, 0);
         if (fill_valid && fill_ready) fill_busy = 1'b1;
         wrote_prev = wr_now;

         if (prev_hold) begin
            chk("resp_hold_valid", resp_valid, 1);
            chk("resp_hold_data", resp_rdata, prev_data);
         end
         if (resp_valid && resp_ready) begin
            chk("resp_expected", exp_q.size() > 0, 1);
            if (exp_q.size() > 0) chk("resp_rdata", resp_rdata, exp_q.pop_front());
         end
         prev_hold = resp_valid && !resp_ready;
         prev_data = resp_rdata;
      end
   end

   // Drivers start between edges and return at posedge+1.
   task automatic do_read(input logic [IW-1:0] idx, input logic [2:0] off);
      int t;
      t = 0;
      req_valid = 1'b1; req_index = idx; req_offset = off;
      do begin @(negedge clk); t++; end while (!req_ready && t < 300);
      chk("req_handshake", req_ready, 1);
      @(posedge clk);
      exp_q.push_back(ref_mem[idx][int'(off) * WW +: WW]);
      #1 req_valid = 1'b0;
   endtask

   task automatic do_fill(input logic [IW-1:0] idx, input logic [LW-1:0] line,
                          input int gap, input int nbeats);
      int t;
      for (int k = 0; k < nbeats; k++) begin
         t = 0;
         fill_valid = 1'b1;
         fill_index = (k == 0) ? idx : IW'($urandom);
         fill_data  = line[k*FW +: FW];
         do begin @(negedge clk); t++; end while (!fill_ready && t < 300);
         chk("fill_handshake", fill_ready, 1);
         @(posedge clk);
         #1 fill_valid = 1'b0;
         if (k == LW / FW - 1) begin
            ref_mem[idx] = line;
            wr_idx_q.push_back(idx);
            wr_line_q.push_back(line);
         end
         if (k < nbeats - 1) repeat (gap) begin @(posedge clk); #1; end
      end
   endtask

   logic [LW-1:0] line_a;
   logic [3:0]    nib;

   initial begin
      for (int i = 0; i < 16; i++) begin ref_mem[i] = '0; sram_mem[i] = '0; end
      rst = 1'b1; req_valid = 1'b0; req_index = '0; req_offset = '0;
      fill_valid = 1'b0; fill_index = '0; fill_data = '0;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_resp_valid", resp_valid, 0);
      chk("rst_resp_rdata", resp_rdata, 0);
      chk("rst_fill_done", fill_done, 0);
      chk("rst_csb", sram_csb0, 1);
      chk("rst_web", sram_web0, 1);
      chk("rst_wmask", sram_wmask0, 0);
      chk("rst_addr", sram_addr0, 0);
      chk("rst_din", sram_din0, 0);
      rst = 1'b0;
      @(negedge clk);
      chk("idle_req_ready", req_ready, 1);
      chk("idle_fill_ready", fill_ready, 1);
      @(posedge clk); #1;

      // Directed fill of index 5, then read offset 2 with latency check.
      for (int k = 0; k < 4; k++) begin nib = 4'(k); line_a[k*FW +: FW] = {16{nib}}; end
      do_fill(5, line_a, 0, 4);
      rr_mode = 1;
      do_read(5, 2);
      @(negedge clk);
      chk("resp_not_in_rd", resp_valid, 0);
      @(posedge clk); #1;
      chk("resp_latency", resp_valid, 1);
      chk("resp_word_5_2", resp_rdata, 32'h11111111);

      // Backpressure for 5 cycles, then a new read issued in the acceptance cycle.
      fork
         do_read(5, 1);
         begin
            repeat (5) begin
               @(negedge clk);
               chk("bp_resp_valid", resp_valid, 1);
               chk("bp_req_ready", req_ready, 0);
            end
            rr_mode = 2;
            @(posedge clk); #1;
            @(negedge clk);
            chk("bp_same_cycle_issue", req_ready && resp_valid && resp_ready, 1);
         end
      join
      repeat (3) begin @(posedge clk); #1; end

      // Fill and read together in IDLE, beats separated by 3-cycle gaps.
      line_a = rand_line();
      fork
         do_fill(7, line_a, 3, 4);
         do_read(7, 4);
         begin
            @(negedge clk);
            chk("prio_req_ready", req_ready, 0);
            chk("prio_fill_ready", fill_ready, 1);
         end
      join

      // Read in the cycle following the line write returns the new line.
      line_a = rand_line();
      do_fill(5, line_a, 0, 4);
      do_read(5, 7);
      repeat (4) begin @(posedge clk); #1; end

      // Reset after two beats: nothing written, then a clean fill of index 9.
      do_fill(9, rand_line(), 1, 2);
      rst = 1'b1;
      repeat (3) begin @(posedge clk); #1; end
      rst = 1'b0;
      @(negedge clk);
      chk("post_rst_fill_ready", fill_ready, 1);
      chk("post_rst_req_ready", req_ready, 1);
      chk("post_rst_resp_valid", resp_valid, 0);
      @(posedge clk); #1;
      do_fill(9, rand_line(), 0, 4);
      do_read(9, 0);
      do_read(9, 5);

      // Random traffic.
      rr_mode = 0;
      repeat (60) begin
         if ($urandom_range(0, 3) == 0)
            do_fill(IW'($urandom), rand_line(), $urandom_range(0, 2), 4);
         else
            do_read(IW'($urandom), 3'($urandom));
         repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
      end

      rr_mode = 2;
      repeat (20) begin @(posedge clk); #1; end
      chk("resp_queue_drained", exp_q.size(), 0);
      chk("write_queue_drained", wr_idx_q.size(), 0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

   initial begin
      #300000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1);
   end

endmodule
